cu_gen2: RTL and testbench

//  Parametrised second-generation control unit FSM for the microprocessor datapath.

---
 rtl/cu_gen2_pkg.sv | 87 ++++++++
 rtl/cu_opdecode.sv | 40 ++++
 rtl/cu_gen2.sv | 131 +++++++++++++
 tb/tb_cu_gen2.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_gen2_pkg.sv
// Shared definitions for the gen-2 control unit: state codes, opcodes, ALU modes,
// decoded-op record and small decode helpers.
package cu_gen2_pkg;

   localparam logic [4:0] S_FETCH_A = 5'd0;
   localparam logic [4:0] S_FETCH_M = 5'd1;
   localparam logic [4:0] S_IR      = 5'd2;
   localparam logic [4:0] S_DEC     = 5'd3;
   localparam logic [4:0] S_ADDR    = 5'd4;
   localparam logic [4:0] S_LD_M    = 5'd5;
   localparam logic [4:0] S_LD_WB   = 5'd6;
   localparam logic [4:0] S_ST_M    = 5'd7;
   localparam logic [4:0] S_ST_W    = 5'd8;
   localparam logic [4:0] S_MOV_A   = 5'd9;
   localparam logic [4:0] S_WB      = 5'd10;
   localparam logic [4:0] S_MI      = 5'd11;
   localparam logic [4:0] S_ALU_A   = 5'd12;
   localparam logic [4:0] S_ALU_X   = 5'd13;
   localparam logic [4:0] S_JMP_A   = 5'd14;
   localparam logic [4:0] S_JMP_M   = 5'd15;
   localparam logic [4:0] S_JMP_L   = 5'd16;
   localparam logic [4:0] S_SKIP    = 5'd17;
   localparam logic [4:0] S_HALT    = 5'd18;

   // Opcodes as seen after zero-extension to 5 bits
   localparam logic [4:0] OPC_LD   = 5'b00000;
   localparam logic [4:0] OPC_ST   = 5'b00001;
   localparam logic [4:0] OPC_MI   = 5'b00010;
   localparam logic [4:0] OPC_MR   = 5'b00011;
   localparam logic [4:0] OPC_SUM  = 5'b00100;
   localparam logic [4:0] OPC_SUB  = 5'b00101;
   localparam logic [4:0] OPC_AND  = 5'b00110;
   localparam logic [4:0] OPC_CM   = 5'b00111;
   localparam logic [4:0] OPC_OR   = 5'b01000;
   localparam logic [4:0] OPC_ORI  = 5'b01001;
   localparam logic [4:0] OPC_XOR  = 5'b01010;
   localparam logic [4:0] OPC_XORI = 5'b01011;
   localparam logic [4:0] OPC_SUMI = 5'b01100;
   localparam logic [4:0] OPC_SUBI = 5'b01101;
   localparam logic [4:0] OPC_ANDI = 5'b01110;
   localparam logic [4:0] OPC_CMI  = 5'b01111;
   localparam logic [4:0] OPC_JMP  = 5'b10000;
   localparam logic [4:0] OPC_JZ   = 5'b10001;
   localparam logic [4:0] OPC_JC   = 5'b10010;
   localparam logic [4:0] OPC_HLT  = 5'b10011;
   localparam logic [4:0] OPC_NOP  = 5'b10100;

   localparam logic [2:0] MODE_ADD  = 3'b000;
   localparam logic [2:0] MODE_SUB  = 3'b001;
   localparam logic [2:0] MODE_CMP  = 3'b010;
   localparam logic [2:0] MODE_AND  = 3'b011;
   localparam logic [2:0] MODE_OR   = 3'b100;
   localparam logic [2:0] MODE_XOR  = 3'b101;
   localparam logic [2:0] MODE_IDLE = 3'b111;

   typedef enum logic [3:0] {
      CL_NONE = 4'd0,
      CL_LD   = 4'd1,
      CL_ST   = 4'd2,
      CL_MI   = 4'd3,
      CL_MR   = 4'd4,
      CL_ALU  = 4'd5,
      CL_JMP  = 4'd6,
      CL_JZ   = 4'd7,
      CL_JC   = 4'd8,
      CL_HLT  = 4'd9
   } op_class_t;

   typedef struct packed {
      op_class_t  cls;
      logic       is_imm;
      logic [2:0] mode;
      logic       writes_rf;
   } op_info_t;

   function automatic logic jump_taken(input op_class_t cls, input logic zero, input logic carry);
      logic taken;
      case (cls)
         CL_JMP:  taken = 1'b1;
         CL_JZ:   taken = zero;
         CL_JC:   taken = carry;
         default: taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/cu_opdecode.sv
// Combinational opcode classifier: opcode -> class, immediate flag, ALU mode and
// whether the op ends with a register-file writeback.
module cu_opdecode
   import cu_gen2_pkg::*;
#(
   parameter int OPC_W = 4
) (
   input  logic [OPC_W-1:0] opc,
   output op_info_t         info
);

   logic [4:0] opc5;

   // Legacy 4-bit codes map onto the low half of the 5-bit space
   always_comb begin
      opc5 = 5'(opc);
      info = '{cls: CL_NONE, is_imm: 1'b0, mode: MODE_IDLE, writes_rf: 1'b0};
      case (opc5)
         OPC_LD:  begin info.cls = CL_LD; info.writes_rf = 1'b1; end
         OPC_ST:  info.cls = CL_ST;
         OPC_MI:  begin info.cls = CL_MI; info.writes_rf = 1'b1; end
         OPC_MR:  begin info.cls = CL_MR; info.writes_rf = 1'b1; end
         OPC_SUM, OPC_SUMI: begin info.cls = CL_ALU; info.mode = MODE_ADD; info.writes_rf = 1'b1; end
         OPC_SUB, OPC_SUBI: begin info.cls = CL_ALU; info.mode = MODE_SUB; info.writes_rf = 1'b1; end
         OPC_AND, OPC_ANDI: begin info.cls = CL_ALU; info.mode = MODE_AND; info.writes_rf = 1'b1; end
         OPC_OR,  OPC_ORI:  begin info.cls = CL_ALU; info.mode = MODE_OR;  info.writes_rf = 1'b1; end
         OPC_XOR, OPC_XORI: begin info.cls = CL_ALU; info.mode = MODE_XOR; info.writes_rf = 1'b1; end
         OPC_CM,  OPC_CMI:  begin info.cls = CL_ALU; info.mode = MODE_CMP; end
         OPC_JMP: info.cls = CL_JMP;
         OPC_JZ:  info.cls = CL_JZ;
         OPC_JC:  info.cls = CL_JC;
         OPC_HLT: info.cls = CL_HLT;
         default: info.cls = CL_NONE;
      endcase
      // Immediate ALU forms are 011xx and 010x1
      info.is_imm = (info.cls == CL_ALU) &&
                    ((opc5[4:2] == 3'b011) || ((opc5[4:3] == 2'b01) && opc5[0]));
   end

endmodule

// File: rtl/cu_gen2.sv
// Second-generation control unit: registered state, combinational strobe/select decode
// with memory wait states, flag-driven jumps and halt.
module cu_gen2
   import cu_gen2_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int OPC_W     = 4,
   parameter int REG_SEL_W = 2
) (
   input  logic                 CU_clk,
   input  logic                 CU_rst,
   input  logic [DATA_W-1:0]    CU_in,
   input  logic                 zero,
   input  logic                 carry,
   input  logic                 mem_ready,
   output logic [2:0]           Mode,
   output logic [REG_SEL_W-1:0] select,
   output logic [7:0]           State,
   output logic                 MBR_we,
   output logic                 IR_we,
   output logic                 PC_inc,
   output logic                 PC_load,
   output logic                 RF_we,
   output logic                 Acc_we,
   output logic                 MAR_we,
   output logic                 RAM_we,
   output logic                 ALU_mux,
   output logic                 RF_mux,
   output logic                 ALU_out_mux,
   output logic                 MAR_mux,
   output logic                 MBR_mux,
   output logic                 Data_imm,
   output logic                 Acc_imm,
   output logic                 halted
);

   logic [4:0]           state;
   logic [4:0]           next_state;
   logic [OPC_W-1:0]     opc;
   logic [REG_SEL_W-1:0] rd;
   logic [REG_SEL_W-1:0] rs;
   op_info_t             info;

   assign opc    = CU_in[DATA_W-1 -: OPC_W];
   assign rd     = CU_in[DATA_W-OPC_W-1 -: REG_SEL_W];
   assign rs     = CU_in[DATA_W-OPC_W-REG_SEL_W-1 -: REG_SEL_W];
   assign State  = {3'b000, state};
   assign halted = (state == S_HALT);

   cu_opdecode #(.OPC_W(OPC_W)) u_opdecode (
      .opc  (opc),
      .info (info)
   );

   // State register
   always_ff @(posedge CU_clk) begin
      if (CU_rst) state <= S_FETCH_A;
      else        state <= next_state;
   end

   // Sequencing; jump conditions are sampled while in S_DEC
   always_comb begin
      next_state = S_FETCH_A;
      case (state)
         S_FETCH_A: next_state = S_FETCH_M;
         S_FETCH_M: next_state = mem_ready ? S_IR : S_FETCH_M;
         S_IR:      next_state = S_DEC;
         S_DEC: begin
            case (info.cls)
               CL_LD, CL_ST:        next_state = S_ADDR;
               CL_MI:               next_state = S_MI;
               CL_MR:               next_state = S_MOV_A;
               CL_ALU:              next_state = S_ALU_A;
               CL_JMP, CL_JZ, CL_JC: next_state = jump_taken(info.cls, zero, carry) ? S_JMP_A : S_SKIP;
               CL_HLT:              next_state = S_HALT;
               default:             next_state = S_FETCH_A;
            endcase
         end
         S_ADDR:    next_state = (info.cls == CL_ST) ? S_ST_M : S_LD_M;
         S_LD_M:    next_state = mem_ready ? S_LD_WB : S_LD_M;
         S_ST_M:    next_state = S_ST_W;
         S_ST_W:    next_state = mem_ready ? S_FETCH_A : S_ST_W;
         S_MOV_A:   next_state = S_WB;
         S_ALU_A:   next_state = S_ALU_X;
         S_ALU_X:   next_state = info.writes_rf ? S_WB : S_FETCH_A;
         S_JMP_A:   next_state = S_JMP_M;
         S_JMP_M:   next_state = mem_ready ? S_JMP_L : S_JMP_M;
         S_HALT:    next_state = S_HALT;
         default:   next_state = S_FETCH_A;
      endcase
   end

   // Output decode; everything idles while reset is held
   always_comb begin
      Mode = MODE_IDLE;   select = {REG_SEL_W{1'b0}};
      MBR_we = 1'b0;  IR_we = 1'b0;  PC_inc = 1'b0;  PC_load = 1'b0;
      RF_we = 1'b0;   Acc_we = 1'b0; MAR_we = 1'b0;  RAM_we = 1'b0;
      ALU_mux = 1'b0; RF_mux = 1'b0; ALU_out_mux = 1'b0; MAR_mux = 1'b0;
      MBR_mux = 1'b0; Data_imm = 1'b0; Acc_imm = 1'b0;
      if (CU_rst) begin
         Mode = MODE_IDLE;
      end else begin
         case (state)
            S_FETCH_A: MAR_we = 1'b1;
            S_FETCH_M: begin MBR_we = 1'b1; PC_inc = mem_ready; end
            S_IR:      IR_we = 1'b1;
            S_ADDR:    begin MAR_we = 1'b1; MAR_mux = 1'b1; end
            S_LD_M:    MBR_we = 1'b1;
            S_LD_WB:   RF_we = 1'b1;
            S_ST_M:    begin MBR_mux = 1'b1; MBR_we = 1'b1; end
            S_ST_W:    RAM_we = 1'b1;
            S_MOV_A:   begin Acc_we = 1'b1; ALU_out_mux = 1'b1; select = rs; end
            S_WB:      begin RF_we = 1'b1; RF_mux = 1'b1; select = rd; end
            S_MI:      begin Data_imm = 1'b1; RF_we = 1'b1; select = rd; end
            S_ALU_A: begin
               Acc_we      = 1'b1;
               Acc_imm     = info.is_imm;
               ALU_out_mux = ~info.is_imm;
               select      = info.is_imm ? {REG_SEL_W{1'b0}} : rs;
            end
            S_ALU_X:   begin Acc_we = 1'b1; ALU_mux = 1'b1; select = rd; Mode = info.mode; end
            S_JMP_A:   MAR_we = 1'b1;
            S_JMP_M:   begin MBR_we = 1'b1; PC_inc = mem_ready; end
            S_JMP_L:   PC_load = 1'b1;
            S_SKIP:    PC_inc = 1'b1;
            default:   Mode = MODE_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cu_gen2.sv
// Directed bench for cu_gen2 in its 5-bit opcode configuration (9-bit instruction word).
module tb_cu_gen2;
   import cu_gen2_pkg::*;

   logic       clk = 1'b0;
   logic       CU_rst = 1'b1;
   logic [8:0] CU_in = 9'd0;
   logic       zero = 1'b0, carry = 1'b0, mem_ready = 1'b1;
   logic [2:0] Mode;
   logic [1:0] select;
   logic [7:0] State;
   logic MBR_we, IR_we, PC_inc, PC_load, RF_we, Acc_we, MAR_we, RAM_we;
   logic ALU_mux, RF_mux, ALU_out_mux, MAR_mux, MBR_mux, Data_imm, Acc_imm, halted;

   int total = 0;
   int bad   = 0;

   // Strobe bits {MBR,IR,PCI,PCL,RF,ACC,MAR,RAM}, select bits {ALU,RF,AOUT,MAR,MBR,DIMM,AIMM}
   localparam logic [7:0] MBR = 8'h80, IRW = 8'h40, PCI = 8'h20, PCL = 8'h10;
   localparam logic [7:0] RFW = 8'h08, ACC = 8'h04, MAR = 8'h02, RAM = 8'h01, N = 8'h00;
   localparam logic [6:0] AM = 7'h40, RM = 7'h20, AOM = 7'h10, MM = 7'h08;
   localparam logic [6:0] BM = 7'h04, DI = 7'h02, AI = 7'h01, NS = 7'h00;
   localparam logic [2:0] IDLE = 3'b111;

   typedef struct packed {
      logic        rst;
      logic        mr;
      logic        z;
      logic        c;
      logic [28:0] e;
   } row_t;

   cu_gen2 #(.DATA_W(9), .OPC_W(5), .REG_SEL_W(2)) dut (
      .CU_clk(clk), .CU_rst(CU_rst), .CU_in(CU_in), .zero(zero), .carry(carry),
      .mem_ready(mem_ready), .Mode(Mode), .select(select), .State(State),
      .MBR_we(MBR_we), .IR_we(IR_we), .PC_inc(PC_inc), .PC_load(PC_load), .RF_we(RF_we),
      .Acc_we(Acc_we), .MAR_we(MAR_we), .RAM_we(RAM_we), .ALU_mux(ALU_mux), .RF_mux(RF_mux),
      .ALU_out_mux(ALU_out_mux), .MAR_mux(MAR_mux), .MBR_mux(MBR_mux), .Data_imm(Data_imm),
      .Acc_imm(Acc_imm), .halted(halted)
   );

   always #5 clk = ~clk;

   function automatic logic [28:0] obs();
      return {halted, State, MBR_we, IR_we, PC_inc, PC_load, RF_we, Acc_we, MAR_we, RAM_we,
              ALU_mux, RF_mux, ALU_out_mux, MAR_mux, MBR_mux, Data_imm, Acc_imm, Mode, select};
   endfunction

   function automatic row_t R(input logic rst, input logic mr, input logic z, input logic c,
                              input logic [4:0] st, input logic [7:0] sb, input logic [6:0] sl,
                              input logic [2:0] md, input logic [1:0] rs);
      row_t r;
      r.rst = rst; r.mr = mr; r.z = z; r.c = c;
      r.e = {st == S_HALT, 3'b000, st, sb, sl, md, rs};
      return r;
   endfunction

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic apply(input row_t r);
      CU_rst = r.rst; mem_ready = r.mr; zero = r.z; carry = r.c;
      #1;
   endtask

   // Walks FETCH_A -> FETCH_M -> IR with memory ready; leaves the DUT in S_DEC
   task automatic do_fetch(input logic [8:0] instr);
      CU_in = instr; CU_rst = 1'b0; mem_ready = 1'b1; zero = 1'b0; carry = 1'b0;
      repeat (3) step();
   endtask

   task automatic test_reset();
      CU_rst = 1'b1; mem_ready = 1'b1;
      step(); step();
      total++;
      if (obs() !== R(1, 1, 0, 0, S_FETCH_A, N, NS, IDLE, 2'd0).e) begin
         bad++; $display("FAIL reset_held got=%h exp=%h", obs(), R(1, 1, 0, 0, S_FETCH_A, N, NS, IDLE, 2'd0).e);
      end
      apply(R(0, 1, 0, 0, S_FETCH_A, N, NS, IDLE, 2'd0));
      total++;
      if (obs() !== R(0, 1, 0, 0, S_FETCH_A, MAR, NS, IDLE, 2'd0).e) begin
         bad++; $display("FAIL reset_release got=%h exp=%h", obs(), R(0, 1, 0, 0, S_FETCH_A, MAR, NS, IDLE, 2'd0).e);
      end
   endtask

   task automatic test_fetch_wait();
      row_t t[$];
      int pcinc = 0, mbrwe = 0;
      CU_in = 9'b00010_11_00;
      t.push_back(R(0, 1, 0, 0, S_FETCH_A, MAR, NS, IDLE, 2'd0));
      t.push_back(R(0, 0, 0, 0, S_FETCH_M, MBR, NS, IDLE, 2'd0));
      t.push_back(R(0, 0, 0, 0, S_FETCH_M, MBR, NS, IDLE, 2'd0));
      t.push_back(R(0, 0, 0, 0, S_FETCH_M, MBR, NS, IDLE, 2'd0));
      t.push_back(R(0, 1, 0, 0, S_FETCH_M, MBR | PCI, NS, IDLE, 2'd0));
      t.push_back(R(0, 1, 0, 0, S_IR, IRW, NS, IDLE, 2'd0));
      t.push_back(R(0, 1, 0, 0, S_DEC, N, NS, IDLE, 2'd0));
      t.push_back(R(0, 1, 0, 0, S_MI, RFW, DI, IDLE, 2'd3));
      t.push_back(R(0, 1, 0, 0, S_FETCH_A, MAR, NS, IDLE, 2'd0));
      for (int i = 0; i < t.size(); i++) begin
         apply(t[i]);
         total++;
         if (obs() !== t[i].e) begin bad++; $display("FAIL fetch_wait[%0d] got=%h exp=%h", i, obs(), t[i].e); end
         pcinc += int'(PC_inc);
         mbrwe += int'(MBR_we);
         if (i < t.size() - 1) step();
      end
      total++;
      if (pcinc !== 1) begin bad++; $display("FAIL fetch_pc_inc_pulses got=%0d exp=1", pcinc); end
      total++;
      if (mbrwe !== 4) begin bad++; $display("FAIL fetch_mbr_we_cycles got=%0d exp=4", mbrwe); end
   endtask

   task automatic test_sum();
      row_t t[$];
      do_fetch(9'b00100_01_10);
      t.push_back(R(0, 1, 0, 0, S_DEC, N, NS, IDLE, 2'd0));
      t.push_back(R(0, 1, 0, 0, S_ALU_A, ACC, AOM, IDLE, 2'd2));
      t.push_back(R(0, 1, 0, 0, S_ALU_X, ACC, AM, 3'b000, 2'd1));
      t.push_back(R(0, 1, 0, 0, S_WB, RFW, RM, IDLE, 2'd1));
      t.push_back(R(0, 1, 0, 0, S_FETCH_A, MAR, NS, IDLE, 2'd0));
      for (int i = 0; i < t.size(); i++) begin
         apply(t[i]);
         total++;
         if (obs() !== t[i].e) begin bad++; $display("FAIL sum[%0d] got=%h exp=%h", i, obs(), t[i].e); end
         if (i < t.size() - 1) step();
      end
   endtask

   task automatic test_cmp_and_imm();
      row_t t[$];
      do_fetch(9'b00111_01_10);
      t.push_back(R(0, 1, 0, 0, S_DEC, N, NS, IDLE, 2'd0));
      t.push_back(R(0, 1, 0, 0, S_ALU_A, ACC, AOM, IDLE, 2'd2));
      t.push_back(R(0, 1, 0, 0, S_ALU_X, ACC, AM, 3'b010, 2'd1));
      t.push_back(R(0, 1, 0, 0, S_FETCH_A, MAR, NS, IDLE, 2'd0));
      for (int i = 0; i < t.size(); i++) begin
         apply(t[i]);
         total++;
         if (obs() !== t[i].e) begin bad++; $display("FAIL cm[%0d] got=%h exp=%h", i, obs(), t[i].e); end
         if (i < t.size() - 1) step();
      end
      t.delete();
      do_fetch(9'b01011_10_00);
      t.push_back(R(0, 1, 0, 0, S_DEC, N, NS, IDLE, 2'd0));
      t.push_back(R(0, 1, 0, 0, S_ALU_A, ACC, AI, IDLE, 2'd0));
      t.push_back(R(0, 1, 0, 0, S_ALU_X, ACC, AM, 3'b101, 2'd2));
      t.push_back(R(0, 1, 0, 0, S_WB, RFW, RM, IDLE, 2'd2));
      t.push_back(R(0, 1, 0, 0, S_FETCH_A, MAR, NS, IDLE, 2'd0));
      for (int i = 0; i < t.size(); i++) begin
         apply(t[i]);
         total++;
         if (obs() !== t[i].e) begin bad++; $display("FAIL xori[%0d] got=%h exp=%h", i, obs(), t[i].e); end
         if (i < t.size() - 1) step();
      end
   endtask

   task automatic test_mr_ld();
      row_t t[$];
      do_fetch(9'b00011_10_01);
      t.push_back(R(0, 1, 0, 0, S_DEC, N, NS, IDLE, 2'd0));
      t.push_back(R(0, 1, 0, 0, S_MOV_A, ACC, AOM, IDLE, 2'd1));
      t.push_back(R(0, 1, 0, 0, S_WB, RFW, RM, IDLE, 2'd2));
      t.push_back(R(0, 1, 0, 0, S_FETCH_A, MAR, NS, IDLE, 2'd0));
      for (int i = 0; i < t.size(); i++) begin
         apply(t[i]);
         total++;
         if (obs() !== t[i].e) begin bad++; $display("FAIL mr[%0d] got=%h exp=%h", i, obs(), t[i].e); end
         if (i < t.size() - 1) step();
      end
      t.delete();
      do_fetch(9'b00000_11_00);
      t.push_back(R(0, 1, 0, 0, S_DEC, N, NS, IDLE, 2'd0));
      t.push_back(R(0, 1, 0, 0, S_ADDR, MAR, MM, IDLE, 2'd0));
      t.push_back(R(0, 0, 0, 0, S_LD_M, MBR, NS, IDLE, 2'd0));
      t.push_back(R(0, 1, 0, 0, S_LD_M, MBR, NS, IDLE, 2'd0));
      t.push_back(R(0, 1, 0, 0, S_LD_WB, RFW, NS, IDLE, 2'd0));
      t.push_back(R(0, 1, 0, 0, S_FETCH_A, MAR, NS, IDLE, 2'd0));
      for (int i = 0; i < t.size(); i++) begin
         apply(t[i]);
         total++;
         if (obs() !== t[i].e) begin bad++; $display("FAIL ld[%0d] got=%h exp=%h", i, obs(), t[i].e); end
         if (i < t.size() - 1) step();
      end
   endtask

   task automatic test_store();
      row_t t[$];
      do_fetch(9'b00001_11_01);
      t.push_back(R(0, 1, 0, 0, S_DEC, N, NS, IDLE, 2'd0));
      t.push_back(R(0, 1, 0, 0, S_ADDR, MAR, MM, IDLE, 2'd0));
      t.push_back(R(0, 1, 0, 0, S_ST_M, MBR, BM, IDLE, 2'd0));
      t.push_back(R(0, 1, 0, 0, S_ST_W, RAM, NS, IDLE, 2'd0));
      t.push_back(R(0, 1, 0, 0, S_FETCH_A, MAR, NS, IDLE, 2'd0));
      for (int i = 0; i < t.size(); i++) begin
         apply(t[i]);
         total++;
         if (obs() !== t[i].e) begin bad++; $display("FAIL st[%0d] got=%h exp=%h", i, obs(), t[i].e); end
         if (i < t.size() - 1) step();
      end
      t.delete();
      do_fetch(9'b00001_11_01);
      t.push_back(R(0, 1, 0, 0, S_DEC, N, NS, IDLE, 2'd0));
      t.push_back(R(0, 1, 0, 0, S_ADDR, MAR, MM, IDLE, 2'd0));
      t.push_back(R(0, 1, 0, 0, S_ST_M, MBR, BM, IDLE, 2'd0));
      t.push_back(R(0, 0, 0, 0, S_ST_W, RAM, NS, IDLE, 2'd0));
      t.push_back(R(0, 0, 0, 0, S_ST_W, RAM, NS, IDLE, 2'd0));
      t.push_back(R(1, 0, 0, 0, S_ST_W, N, NS, IDLE, 2'd0));
      t.push_back(R(0, 0, 0, 0, S_FETCH_A, MAR, NS, IDLE, 2'd0));
      for (int i = 0; i < t.size(); i++) begin
         apply(t[i]);
         total++;
         if (obs() !== t[i].e) begin bad++; $display("FAIL st_reset[%0d] got=%h exp=%h", i, obs(), t[i].e); end
         if (i < t.size() - 1) step();
      end
   endtask

   task automatic test_jumps();
      row_t t[$];
      int pcinc = 0, pcload = 0;
      do_fetch(9'b10001_00_00);
      t.push_back(R(0, 1, 0, 1, S_DEC, N, NS, IDLE, 2'd0));
      t.push_back(R(0, 1, 1, 1, S_SKIP, PCI, NS, IDLE, 2'd0));
      t.push_back(R(0, 1, 0, 0, S_FETCH_A, MAR, NS, IDLE, 2'd0));
      for (int i = 0; i < t.size(); i++) begin
         apply(t[i]);
         total++;
         if (obs() !== t[i].e) begin bad++; $display("FAIL jz_nt[%0d] got=%h exp=%h", i, obs(), t[i].e); end
         pcinc += int'(PC_inc);
         pcload += int'(PC_load);
         if (i < t.size() - 1) step();
      end
      total++;
      if (pcinc !== 1 || pcload !== 0) begin
         bad++; $display("FAIL jz_nt_pc got inc=%0d load=%0d exp inc=1 load=0", pcinc, pcload);
      end
      t.delete(); pcload = 0;
      do_fetch(9'b10001_00_00);
      t.push_back(R(0, 1, 1, 0, S_DEC, N, NS, IDLE, 2'd0));
      t.push_back(R(0, 1, 0, 0, S_JMP_A, MAR, NS, IDLE, 2'd0));
      t.push_back(R(0, 0, 0, 0, S_JMP_M, MBR, NS, IDLE, 2'd0));
      t.push_back(R(0, 1, 0, 0, S_JMP_M, MBR | PCI, NS, IDLE, 2'd0));
      t.push_back(R(0, 1, 0, 0, S_JMP_L, PCL, NS, IDLE, 2'd0));
      t.push_back(R(0, 1, 0, 0, S_FETCH_A, MAR, NS, IDLE, 2'd0));
      for (int i = 0; i < t.size(); i++) begin
         apply(t[i]);
         total++;
         if (obs() !== t[i].e) begin bad++; $display("FAIL jz_t[%0d] got=%h exp=%h", i, obs(), t[i].e); end
         pcload += int'(PC_load);
         if (i < t.size() - 1) step();
      end
      total++;
      if (pcload !== 1) begin bad++; $display("FAIL jz_t_pc_load got=%0d exp=1", pcload); end
      t.delete();
      do_fetch(9'b10010_00_00);
      t.push_back(R(0, 1, 1, 0, S_DEC, N, NS, IDLE, 2'd0));
      t.push_back(R(0, 1, 1, 1, S_SKIP, PCI, NS, IDLE, 2'd0));
      t.push_back(R(0, 1, 0, 0, S_FETCH_A, MAR, NS, IDLE, 2'd0));
      for (int i = 0; i < t.size(); i++) begin
         apply(t[i]);
         total++;
         if (obs() !== t[i].e) begin bad++; $display("FAIL jc_nt[%0d] got=%h exp=%h", i, obs(), t[i].e); end
         if (i < t.size() - 1) step();
      end
      t.delete();
      do_fetch(9'b10000_00_00);
      t.push_back(R(0, 1, 0, 0, S_DEC, N, NS, IDLE, 2'd0));
      t.push_back(R(0, 1, 0, 0, S_JMP_A, MAR, NS, IDLE, 2'd0));
      t.push_back(R(0, 1, 0, 0, S_JMP_M, MBR | PCI, NS, IDLE, 2'd0));
      t.push_back(R(0, 1, 0, 0, S_JMP_L, PCL, NS, IDLE, 2'd0));
      t.push_back(R(0, 1, 0, 0, S_FETCH_A, MAR, NS, IDLE, 2'd0));
      for (int i = 0; i < t.size(); i++) begin
         apply(t[i]);
         total++;
         if (obs() !== t[i].e) begin bad++; $display("FAIL jmp[%0d] got=%h exp=%h", i, obs(), t[i].e); end
         if (i < t.size() - 1) step();
      end
   endtask

   task automatic test_nop_unused();
      logic [8:0] ops [2];
      ops[0] = 9'b10100_01_01;
      ops[1] = 9'b10111_01_01;
      for (int k = 0; k < 2; k++) begin
         do_fetch(ops[k]);
         total++;
         if (obs() !== R(0, 1, 0, 0, S_DEC, N, NS, IDLE, 2'd0).e) begin
            bad++; $display("FAIL nop%0d_dec got=%h exp=%h", k, obs(), R(0, 1, 0, 0, S_DEC, N, NS, IDLE, 2'd0).e);
         end
         step();
         total++;
         if (obs() !== R(0, 1, 0, 0, S_FETCH_A, MAR, NS, IDLE, 2'd0).e) begin
            bad++; $display("FAIL nop%0d_ret got=%h exp=%h", k, obs(), R(0, 1, 0, 0, S_FETCH_A, MAR, NS, IDLE, 2'd0).e);
         end
      end
   endtask

   task automatic test_halt();
      row_t h;
      do_fetch(9'b10011_00_00);
      step();
      h = R(0, 1, 1, 1, S_HALT, N, NS, IDLE, 2'd0);
      for (int i = 0; i < 100; i++) begin
         apply(h);
         total++;
         if (obs() !== h.e) begin bad++; $display("FAIL halt[%0d] got=%h exp=%h", i, obs(), h.e); end
         step();
      end
      apply(R(1, 1, 0, 0, S_HALT, N, NS, IDLE, 2'd0));
      step();
      apply(R(0, 1, 0, 0, S_FETCH_A, MAR, NS, IDLE, 2'd0));
      total++;
      if (obs() !== R(0, 1, 0, 0, S_FETCH_A, MAR, NS, IDLE, 2'd0).e) begin
         bad++; $display("FAIL halt_exit got=%h exp=%h", obs(), R(0, 1, 0, 0, S_FETCH_A, MAR, NS, IDLE, 2'd0).e);
      end
   endtask

   initial begin
      test_reset();
      test_fetch_wait();
      test_sum();
      test_cmp_and_imm();
      test_mr_ld();
      test_store();
      test_jumps();
      test_nop_unused();
      test_halt();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
